// File: rtl/clock_freq_meter.sv
// Frequency/period meter for a slow asynchronous signal sampled in the clk domain.
// Counts rising edges per fixed gate window and clk cycles between consecutive edges.
module clock_freq_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PER_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic [PER_W-1:0] period_cycles,
    output logic             meas_valid,
    output logic             period_valid,
    output logic             no_signal,
    output logic             cnt_ovf
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);

    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [PER_W-1:0] PER_MAX   = {PER_W{1'b1}};

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_GATE = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_q, edge_d;
    logic [0:0]             state_q, state_d;
    logic [GW-1:0]          gate_q, gate_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic                   armed_q, armed_d;
    logic [PER_W-1:0]       per_acc_q, per_acc_d;
    logic [CNT_W-1:0]       freq_q, freq_d;
    logic [PER_W-1:0]       per_q, per_d;
    logic                   mvalid_q, mvalid_d;
    logic                   pvalid_q, pvalid_d;
    logic                   nosig_q, nosig_d;
    logic                   cov_q, cov_d;

    logic [CNT_W-1:0] acc_nx;
    logic             ovf_nx;
    logic [PER_W-1:0] per_inc;

    // Edge total including this cycle's pulse, saturating at CNT_MAX.
    always_comb begin
        acc_nx = acc_q;
        ovf_nx = ovf_q;
        if (edge_q) begin
            if (acc_q == CNT_MAX) begin
                ovf_nx = 1'b1;
            end else begin
                acc_nx = acc_q + CNT_W'(1);
            end
        end
        per_inc = (per_acc_q == PER_MAX) ? PER_MAX : per_acc_q + PER_W'(1);
    end

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d   = sync_q[SYNC_STAGES-1];
        edge_d   = sync_q[SYNC_STAGES-1] & ~prev_q;
        state_d  = state_q;
        gate_d   = gate_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        freq_d   = freq_q;
        nosig_d  = nosig_q;
        cov_d    = cov_q;
        mvalid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                gate_d = '0;
                acc_d  = '0;
                ovf_d  = 1'b0;
                if (en) state_d = S_GATE;
            end
            S_GATE: begin
                if (gate_q == GATE_LAST) begin
                    freq_d   = acc_nx;
                    nosig_d  = (acc_nx == '0);
                    cov_d    = ovf_nx;
                    mvalid_d = 1'b1;
                    gate_d   = '0;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = en ? S_GATE : S_IDLE;
                end else if (!en) begin
                    gate_d  = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gate_d = gate_q + GW'(1);
                    acc_d  = acc_nx;
                    ovf_d  = ovf_nx;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Edge pulse restarts the distance count at 1 so the next edge reads t1-t0.
    always_comb begin
        armed_d   = armed_q;
        per_acc_d = per_acc_q;
        per_d     = per_q;
        pvalid_d  = 1'b0;
        if (!en) begin
            armed_d   = 1'b0;
            per_acc_d = '0;
        end else if (edge_q) begin
            if (armed_q) begin
                per_d    = per_acc_q;
                pvalid_d = 1'b1;
            end
            armed_d   = 1'b1;
            per_acc_d = PER_W'(1);
        end else begin
            per_acc_d = per_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            edge_q    <= 1'b0;
            state_q   <= S_IDLE;
            gate_q    <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            armed_q   <= 1'b0;
            per_acc_q <= '0;
            freq_q    <= '0;
            per_q     <= '0;
            mvalid_q  <= 1'b0;
            pvalid_q  <= 1'b0;
            nosig_q   <= 1'b0;
            cov_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            edge_q    <= edge_d;
            state_q   <= state_d;
            gate_q    <= gate_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            armed_q   <= armed_d;
            per_acc_q <= per_acc_d;
            freq_q    <= freq_d;
            per_q     <= per_d;
            mvalid_q  <= mvalid_d;
            pvalid_q  <= pvalid_d;
            nosig_q   <= nosig_d;
            cov_q     <= cov_d;
        end
    end

    assign freq_count    = freq_q;
    assign period_cycles = per_q;
    assign meas_valid    = mvalid_q;
    assign period_valid  = pvalid_q;
    assign no_signal     = nosig_q;
    assign cnt_ovf       = cov_q;

endmodule
